// File: rtl/keypad_matrix_scan.sv
// 4x4 active-low keypad scanner with frame-level debounce, producing a one-hot key bus.
// Define KEYPAD_AUTOREPEAT_EN to add key_valid auto-repeat while a key stays held.
module keypad_matrix_scan #(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_RATE     = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  col_in,
  output logic [3:0]  row_out,
  output logic [15:0] onehot,
  output logic [3:0]  key_code,
  output logic        key_valid
);

  localparam int SLOT_W  = $clog2(SCAN_DIV);
  localparam int AGREE_W = $clog2(DEBOUNCE_FRAMES + 1);

  logic [3:0]         col_s1_reg, col_s2_reg;
  logic [SLOT_W-1:0]  slot_cnt_reg;
  logic [1:0]         row_idx_reg;
  logic               slot_end;
  logic               frame_done_reg;
  logic [15:0]        frame_word;
  logic               frame_zero, frame_single, frame_valid;
  logic [15:0]        cand_reg, cand_next;
  logic [AGREE_W-1:0] agree_reg, agree_next;
  logic               accept;
  logic [15:0]        onehot_reg;
  logic [3:0]         key_code_reg;
  logic               key_valid_reg;

  function automatic logic [3:0] onehot_index(input logic [15:0] v);
    onehot_index = '0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) onehot_index = 4'(i);
    end
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_s1_reg <= 4'hF;
      col_s2_reg <= 4'hF;
    end else begin
      col_s1_reg <= col_in;
      col_s2_reg <= col_s1_reg;
    end
  end

  assign slot_end = (slot_cnt_reg == SLOT_W'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_reg   <= '0;
      row_idx_reg    <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= slot_end && (row_idx_reg == 2'd3);
      if (slot_end) begin
        slot_cnt_reg <= '0;
        row_idx_reg  <= row_idx_reg + 2'd1;
      end else begin
        slot_cnt_reg <= slot_cnt_reg + SLOT_W'(1);
      end
    end
  end

  assign row_out = ~(4'b0001 << row_idx_reg);

  // Each row owns its nibble of the frame word; a pressed key reads 0, stored as 1.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_row
      logic [3:0] row_bits_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          row_bits_reg <= '0;
        end else if (slot_end && (row_idx_reg == 2'(gi))) begin
          row_bits_reg <= ~col_s2_reg;
        end
      end
      assign frame_word[gi*4 +: 4] = row_bits_reg;
    end
  endgenerate

  assign frame_zero   = (frame_word == 16'h0000);
  assign frame_single = !frame_zero && ((frame_word & (frame_word - 16'd1)) == 16'h0000);
  assign frame_valid  = frame_zero || frame_single;

  // Ghost frames (two or more keys) leave the debounce state untouched.
  always_comb begin
    cand_next  = cand_reg;
    agree_next = agree_reg;
    accept     = 1'b0;
    if (frame_done_reg && frame_valid) begin
      if (frame_word == cand_reg) begin
        if (agree_reg < AGREE_W'(DEBOUNCE_FRAMES)) agree_next = agree_reg + AGREE_W'(1);
      end else begin
        cand_next  = frame_word;
        agree_next = AGREE_W'(1);
      end
      accept = (agree_next == AGREE_W'(DEBOUNCE_FRAMES)) && (cand_next != onehot_reg);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_reg  <= '0;
      agree_reg <= '0;
    end else begin
      cand_reg  <= cand_next;
      agree_reg <= agree_next;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt_reg;
  logic             rep_first_done_reg;
  logic             rep_fire;

  // First repeat waits REPEAT_DELAY frames after acceptance, later ones REPEAT_RATE.
  always_comb begin
    rep_fire = 1'b0;
    if (frame_done_reg && !accept && (onehot_reg != 16'h0000)) begin
      if (rep_first_done_reg) rep_fire = ((rep_cnt_reg + REP_W'(1)) == REP_W'(REPEAT_RATE));
      else                    rep_fire = ((rep_cnt_reg + REP_W'(1)) == REP_W'(REPEAT_DELAY));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_reg        <= '0;
      rep_first_done_reg <= 1'b0;
    end else if (accept) begin
      rep_cnt_reg        <= '0;
      rep_first_done_reg <= 1'b0;
    end else if (frame_done_reg && (onehot_reg != 16'h0000)) begin
      if (rep_fire) begin
        rep_cnt_reg        <= '0;
        rep_first_done_reg <= 1'b1;
      end else begin
        rep_cnt_reg <= rep_cnt_reg + REP_W'(1);
      end
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_RATE};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      onehot_reg    <= '0;
      key_code_reg  <= '0;
      key_valid_reg <= 1'b0;
    end else begin
      key_valid_reg <= 1'b0;
      if (accept) begin
        onehot_reg <= cand_next;
        if (cand_next != 16'h0000) begin
          key_code_reg  <= onehot_index(cand_next);
          key_valid_reg <= 1'b1;
        end
      end
`ifdef KEYPAD_AUTOREPEAT_EN
      else if (rep_fire) begin
        key_valid_reg <= 1'b1;
      end
`endif
    end
  end

  assign onehot    = onehot_reg;
  assign key_code  = key_code_reg;
  assign key_valid = key_valid_reg;

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// Frame-level bench for keypad_matrix_scan: a keypad model feeds col_in from row_out
// and a per-frame reference model predicts onehot / key_code / key_valid.
module tb_keypad_matrix_scan;

  localparam int SD = 4;
  localparam int DF = 3;
  localparam int RD = 5;
  localparam int RR = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [15:0] onehot;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [15:0] pressed = 16'h0000;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [15:0] m_cand, m_onehot;
  logic [3:0]  m_code;
  int          m_agree, m_pulse, m_rep;

  keypad_matrix_scan #(
    .SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .col_in(col_in), .row_out(row_out),
    .onehot(onehot), .key_code(key_code), .key_valid(key_valid)
  );

  always #5 clk = ~clk;

  // A pressed key on the driven (low) row pulls its column low.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      if (row_out[r] == 1'b0)
        for (int c = 0; c < 4; c++)
          if (pressed[r*4 + c]) col_in[c] = 1'b0;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cand = '0; m_onehot = '0; m_code = '0;
    m_agree = 0; m_pulse = 0; m_rep = 0;
  endtask

  // One whole frame seen with key set 'mask'; m_pulse is what key_valid shows next frame.
  task automatic model_frame(input logic [15:0] mask);
    bit accepted = 0;
    m_pulse = 0;
    if ($countones(mask) <= 1) begin
      if (mask == m_cand) m_agree = (m_agree < DF) ? m_agree + 1 : DF;
      else begin m_cand = mask; m_agree = 1; end
      if (m_agree == DF && m_cand != m_onehot) begin
        accepted = 1;
        m_onehot = m_cand;
        m_rep = 0;
        if (m_cand != 0) begin
          m_code = 4'($clog2(m_cand));
          m_pulse = 1;
        end
      end
    end
`ifdef KEYPAD_AUTOREPEAT_EN
    if (!accepted && m_onehot != 0) begin
      m_rep++;
      if (m_rep == RD || (m_rep > RD && (m_rep - RD) % RR == 0)) m_pulse = 1;
    end
`else
    if (accepted) m_rep = 0;
`endif
  endtask

  // Entered on the negedge just before a frame's first edge; leaves at the same phase.
  task automatic play(input logic [15:0] mask, input int frames, input string tag);
    pressed = mask;
    for (int f = 0; f < frames; f++) begin
      int kv = 0;
      for (int i = 0; i < 4*SD; i++) begin
        logic [3:0] exp_row;
        @(posedge clk);
        @(negedge clk);
        exp_row = ~(4'b0001 << (((i + 1) / SD) % 4));
        check_eq($sformatf("%s.row_out f%0d c%0d", tag, f, i), 32'(row_out), 32'(exp_row));
        if (i == 0) begin
          check_eq($sformatf("%s.onehot f%0d", tag, f), 32'(onehot), 32'(m_onehot));
          check_eq($sformatf("%s.key_code f%0d", tag, f), 32'(key_code), 32'(m_code));
          check_eq($sformatf("%s.key_valid f%0d", tag, f), 32'(key_valid), 32'(m_pulse));
        end
        kv += int'(key_valid);
      end
      check_eq($sformatf("%s.kv_count f%0d", tag, f), 32'(kv), 32'(m_pulse));
      $display("frame %s/%0d mask=%04h onehot=%04h key_code=%0h kv_pulses=%0d", tag, f, mask, onehot, key_code, kv);
      model_frame(mask);
    end
  endtask

  initial begin
    logic [15:0] mask;
    int kind, a, b;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("reset.row_out", 32'(row_out), 32'(4'b1110));
    check_eq("reset.onehot", 32'(onehot), 32'h0);
    check_eq("reset.key_code", 32'(key_code), 32'h0);
    check_eq("reset.key_valid", 32'(key_valid), 32'h0);
    rst_n = 1'b1;

    play(16'h0000, 10, "idle");
    play(16'h0040, 4, "press");
    play(16'h0000, 4, "release");
    for (int j = 0; j < 6; j++) play((j % 2 == 0) ? 16'h1000 : 16'h0000, 1, "bounce");
    play(16'h1000, 4, "settle");
    play(16'h0000, 4, "release2");
    play(16'h0202, 6, "ghost");
    play(16'h0002, 4, "unghost");
    play(16'h0400, 4, "prereset");

    // reset in the middle of the row-2 slot must clear outputs without a clock edge
    for (int i = 0; i < 2*SD + 1; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    check_eq("midreset.onehot", 32'(onehot), 32'h0);
    check_eq("midreset.row_out", 32'(row_out), 32'(4'b1110));
    check_eq("midreset.key_code", 32'(key_code), 32'h0);
    $display("midreset onehot=%04h row_out=%b", onehot, row_out);
    @(negedge clk);
    @(negedge clk);
    check_eq("midreset.hold_row_out", 32'(row_out), 32'(4'b1110));
    rst_n = 1'b1;
    model_reset();
    play(16'h0400, 5, "reaccept");

`ifdef KEYPAD_AUTOREPEAT_EN
    play(16'h0000, 4, "pre_repeat");
    play(16'h0008, 16, "repeat");
`endif

    for (int s = 0; s < 40; s++) begin
      kind = $urandom_range(0, 3);
      a = $urandom_range(0, 15);
      b = (a + $urandom_range(1, 15)) % 16;
      case (kind)
        0:       mask = 16'h0000;
        3:       mask = (16'h0001 << a) | (16'h0001 << b);
        default: mask = 16'h0001 << a;
      endcase
      play(mask, $urandom_range(1, 5), $sformatf("rnd%0d", s));
    end
    play(16'h0000, 4, "final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
